fp_add_arbiter: RTL and testbench

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter.sv | 113 +++++++++++
 tb/tb_fp_add_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency FP adder.
// One operation in flight at a time; the response is held until rsp_ready.
module fp_add_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_sub,
  input  logic [XLEN-1:0]   req_a0,
  input  logic [XLEN-1:0]   req_b0,
  input  logic [XLEN-1:0]   req_a1,
  input  logic [XLEN-1:0]   req_b1,
  output logic [XLEN-1:0]   add_a,
  output logic [XLEN-1:0]   add_b,
  output logic              add_start,
  input  logic [XLEN-1:0]   add_result,
  input  logic              add_overflow,
  input  logic              add_underflow,
  input  logic              add_exception,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [XLEN-1:0]   rsp_result,
  output logic [2:0]        rsp_flags,
  output logic [CNT_W-1:0]  done_cnt0,
  output logic [CNT_W-1:0]  done_cnt1
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;
  localparam logic [3:0] LatInit = 4'(ADD_LAT);

  logic [1:0]      state_q, state_d;
  logic [3:0]      lat_cnt_q;
  logic            last_grant_q;
  logic            cur_id_q;
  logic            grant;
  logic            accept;
  logic            handshake;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    grant     = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    req_ready = 2'b00;
    if (state_q == StIdle && !rst) begin
      req_ready = {req_valid[1] & grant, req_valid[0] & ~grant};
    end
  end

  assign accept    = |req_ready;
  assign rsp_valid = (state_q == StResp);
  assign handshake = rsp_valid & rsp_ready;
  assign sel_a     = grant ? req_a1 : req_a0;
  // Subtraction is addition with the sign of B flipped; no other bits are touched.
  assign sel_b     = (grant ? req_b1 : req_b0) ^ {req_sub[grant], {(XLEN-1){1'b0}}};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      StBusy:  if (lat_cnt_q == 4'd1) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      lat_cnt_q    <= 4'd0;
      last_grant_q <= 1'b1;
      cur_id_q     <= 1'b0;
      add_a        <= '0;
      add_b        <= '0;
      add_start    <= 1'b0;
      rsp_result   <= '0;
      rsp_flags    <= 3'b000;
      rsp_id       <= 1'b0;
      done_cnt0    <= '0;
      done_cnt1    <= '0;
    end else begin
      state_q   <= state_d;
      add_start <= accept;
      if (accept) begin
        add_a     <= sel_a;
        add_b     <= sel_b;
        cur_id_q  <= grant;
        lat_cnt_q <= LatInit;
      end
      if (state_q == StBusy) begin
        lat_cnt_q <= lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) begin
          rsp_result <= add_result;
          rsp_flags  <= {add_overflow, add_underflow, add_exception};
          rsp_id     <= cur_id_q;
        end
      end
      if (handshake) begin
        last_grant_q <= rsp_id;
        if (!rsp_id && done_cnt0 != {CNT_W{1'b1}}) done_cnt0 <= done_cnt0 + CNT_W'(1);
        if (rsp_id && done_cnt1 != {CNT_W{1'b1}}) done_cnt1 <= done_cnt1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: instance 0 uses ADD_LAT=3/CNT_W=16, instance 1 ADD_LAT=1/CNT_W=2.
// A transaction-level model predicts every output each cycle; a stand-in adder drives noise.
module tb_fp_add_arbiter;

  logic        clk = 1'b0;
  logic        rst [2];
  logic [1:0]  req_valid [2];
  logic [1:0]  req_ready [2];
  logic [1:0]  req_sub [2];
  logic [31:0] req_a0 [2];
  logic [31:0] req_b0 [2];
  logic [31:0] req_a1 [2];
  logic [31:0] req_b1 [2];
  logic [31:0] add_a [2];
  logic [31:0] add_b [2];
  logic        add_start [2];
  logic [31:0] add_result [2];
  logic        add_ovf [2];
  logic        add_unf [2];
  logic        add_exc [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_id [2];
  logic [31:0] rsp_result [2];
  logic [2:0]  rsp_flags [2];
  logic [15:0] dc0_a, dc1_a;
  logic [1:0]  dc0_b, dc1_b;

  always #5 clk = ~clk;

  fp_add_arbiter #(.XLEN(32), .ADD_LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_sub(req_sub[0]), .req_a0(req_a0[0]), .req_b0(req_b0[0]), .req_a1(req_a1[0]),
    .req_b1(req_b1[0]), .add_a(add_a[0]), .add_b(add_b[0]), .add_start(add_start[0]),
    .add_result(add_result[0]), .add_overflow(add_ovf[0]), .add_underflow(add_unf[0]),
    .add_exception(add_exc[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_id(rsp_id[0]), .rsp_result(rsp_result[0]), .rsp_flags(rsp_flags[0]),
    .done_cnt0(dc0_a), .done_cnt1(dc1_a)
  );

  fp_add_arbiter #(.XLEN(32), .ADD_LAT(1), .CNT_W(2)) u_lat1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_sub(req_sub[1]), .req_a0(req_a0[1]), .req_b0(req_b0[1]), .req_a1(req_a1[1]),
    .req_b1(req_b1[1]), .add_a(add_a[1]), .add_b(add_b[1]), .add_start(add_start[1]),
    .add_result(add_result[1]), .add_overflow(add_ovf[1]), .add_underflow(add_unf[1]),
    .add_exception(add_exc[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_id(rsp_id[1]), .rsp_result(rsp_result[1]), .rsp_flags(rsp_flags[1]),
    .done_cnt0(dc0_b), .done_cnt1(dc1_b)
  );

  function automatic int lat(int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic int cnt_max(int d);
    return (d == 0) ? 65535 : 3;
  endfunction

  // Stand-in adder: a few real IEEE sums, otherwise an arbitrary mix of the operands.
  function automatic logic [31:0] adder_fn(logic [31:0] x, logic [31:0] y);
    if (x == 32'h3F80_0000 && y == 32'h4000_0000) return 32'h4040_0000;
    if (x == 32'h4040_0000 && y == 32'hBF80_0000) return 32'h4000_0000;
    if (x == 32'h3FC0_0000 && y == 32'h4020_0000) return 32'h4080_0000;
    return (x ^ {y[15:0], y[31:16]}) + 32'h0123_4567;
  endfunction

  function automatic logic [2:0] flag_fn(logic [31:0] x, logic [31:0] y);
    return {x[31] ^ y[31], x[0] ^ y[1], ^(x[7:0] ^ y[7:0])};
  endfunction

  // Result is meaningful only in the cycle before the sampling edge; noise otherwise.
  int age [2] = '{0, 0};
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (add_start[d] === 1'b1) age[d] = 1;
      else if (age[d] != 0 && age[d] < lat(d)) age[d] = age[d] + 1;
      else age[d] = 0;
      if (age[d] == lat(d)) begin
        add_result[d] = adder_fn(add_a[d], add_b[d]);
        {add_ovf[d], add_unf[d], add_exc[d]} = flag_fn(add_a[d], add_b[d]);
      end else begin
        add_result[d] = $urandom;
        {add_ovf[d], add_unf[d], add_exc[d]} = 3'($urandom);
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cur_d = 0;
  int cyc [2] = '{0, 0};

  // Model: at most one transaction, timed from its acceptance cycle.
  logic        m_busy [2];
  int          m_acc [2];
  logic        m_id [2];
  logic        m_last [2];
  logic [31:0] m_a [2];
  logic [31:0] m_b [2];
  int          m_cnt [2][2];

  logic        acc_now, hs_now, obs_valid, obs_id, obs_start;
  logic [1:0]  obs_ready;
  logic [31:0] obs_res, obs_addb;
  logic [2:0]  obs_flags;
  logic [31:0] obs_cnt0, obs_cnt1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d cyc=%0d got %h want %h", nm, cur_d, cyc[cur_d], act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_busy[d] = 1'b0;
    m_last[d] = 1'b1;
    m_a[d] = '0;
    m_b[d] = '0;
    m_cnt[d][0] = 0;
    m_cnt[d][1] = 0;
  endtask

  task automatic step(input int d, input logic r, input logic [1:0] v, input logic [1:0] sb,
                      input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] x1,
                      input logic [31:0] y1, input logic rr);
    logic eg, es, ev;
    logic [1:0] er;
    @(negedge clk);
    rst[d] = r; req_valid[d] = v; req_sub[d] = sb;
    req_a0[d] = x0; req_b0[d] = y0; req_a1[d] = x1; req_b1[d] = y1; rsp_ready[d] = rr;
    #1;
    cur_d = d;
    eg = (v == 2'b11) ? ~m_last[d] : v[1];
    er = (r || m_busy[d]) ? 2'b00 : (v & (eg ? 2'b10 : 2'b01));
    es = m_busy[d] && (cyc[d] == m_acc[d] + 1);
    ev = m_busy[d] && (cyc[d] >= m_acc[d] + lat(d) + 1);
    obs_cnt0 = (d == 0) ? 32'(dc0_a) : 32'(dc0_b);
    obs_cnt1 = (d == 0) ? 32'(dc1_a) : 32'(dc1_b);
    obs_valid = rsp_valid[d]; obs_id = rsp_id[d]; obs_res = rsp_result[d];
    obs_flags = rsp_flags[d]; obs_ready = req_ready[d]; obs_start = add_start[d];
    obs_addb = add_b[d];
    chk("req_ready", 32'(obs_ready), 32'(er));
    chk("add_start", 32'(obs_start), 32'(es));
    chk("rsp_valid", 32'(obs_valid), 32'(ev));
    chk("add_a", add_a[d], m_a[d]);
    chk("add_b", obs_addb, m_b[d]);
    chk("done_cnt0", obs_cnt0, 32'(m_cnt[d][0]));
    chk("done_cnt1", obs_cnt1, 32'(m_cnt[d][1]));
    if (ev) begin
      chk("rsp_result", obs_res, adder_fn(m_a[d], m_b[d]));
      chk("rsp_flags", 32'(obs_flags), 32'(flag_fn(m_a[d], m_b[d])));
      chk("rsp_id", 32'(obs_id), 32'(m_id[d]));
    end
    acc_now = 1'b0;
    hs_now = 1'b0;
    if (r) begin
      model_reset(d);
    end else if (|er) begin
      acc_now = 1'b1;
      m_busy[d] = 1'b1;
      m_acc[d] = cyc[d];
      m_id[d] = eg;
      m_a[d] = eg ? x1 : x0;
      m_b[d] = (eg ? y1 : y0) ^ {sb[eg], 31'b0};
    end else if (ev && rr) begin
      hs_now = 1'b1;
      m_busy[d] = 1'b0;
      m_last[d] = m_id[d];
      if (m_cnt[d][m_id[d]] < cnt_max(d)) m_cnt[d][m_id[d]]++;
    end
    cyc[d]++;
  endtask

  task automatic idle_step(input int d, input logic rr);
    step(d, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, rr);
  endtask

  task automatic reset_dut(input int d);
    step(d, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    step(d, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // Raise one request until accepted; returns whether it was.
  task automatic request(input int d, input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic sb, input logic rr, output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 8 && !ok; t++) begin
      step(d, 1'b0, id ? 2'b10 : 2'b01, {sb, sb}, id ? 32'h0 : a, id ? 32'h0 : b,
           id ? a : 32'h0, id ? b : 32'h0, rr);
      ok = acc_now;
    end
    chk("accepted", 32'(ok), 32'd1);
  endtask

  task automatic do_txn(input int d, input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic sb, input logic [31:0] exp_b, input logic [31:0] exp_res);
    logic ok;
    int n;
    request(d, id, a, b, sb, 1'b1, ok);
    idle_step(d, 1'b1);
    n = 1;
    chk("latched_b", obs_addb, exp_b);
    chk("first_busy_start", 32'(obs_start), 32'd1);
    while (!obs_valid && n < 20) begin
      idle_step(d, 1'b1);
      n++;
    end
    chk("rsp_latency", 32'(n), 32'(lat(d) + 1));
    chk("result_value", obs_res, exp_res);
    chk("result_id", 32'(obs_id), 32'(id));
  endtask

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp_b;
    logic [31:0] exp_res;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic ok;
    logic [2:0] snap_flags;
    logic [31:0] snap_res;
    logic snap_id;
    logic ids [$];
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 2'b00; req_sub[d] = 2'b00; rsp_ready[d] = 1'b0;
      req_a0[d] = '0; req_b0[d] = '0; req_a1[d] = '0; req_b1[d] = '0;
      model_reset(d);
    end
    tbl[0] = '{1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4000_0000, 32'h4040_0000};
    tbl[1] = '{1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 32'h4000_0000};
    tbl[2] = '{1'b0, 32'h7FC0_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000,
               adder_fn(32'h7FC0_0000, 32'hFF80_0000)};
    tbl[3] = '{1'b1, 32'h0000_0001, 32'h8000_0001, 1'b1, 32'h0000_0001,
               adder_fn(32'h0000_0001, 32'h0000_0001)};
    tbl[4] = '{1'b0, 32'h3FC0_0000, 32'h4020_0000, 1'b0, 32'h4020_0000, 32'h4080_0000};

    // Single transactions at ADD_LAT=1, then counter saturation at CNT_W=2.
    reset_dut(1);
    for (int k = 0; k < 5; k++) begin
      do_txn(1, tbl[k].id, tbl[k].a, tbl[k].b, tbl[k].sub, tbl[k].exp_b, tbl[k].exp_res);
      if (k == 0) begin
        idle_step(1, 1'b1);
        chk("first_done_cnt0", obs_cnt0, 32'd1);
      end
    end
    for (int k = 0; k < 2; k++)
      do_txn(1, 1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4000_0000, 32'h4040_0000);
    idle_step(1, 1'b1);
    chk("sat_done_cnt0", obs_cnt0, 32'd3);
    chk("done_cnt1_after", obs_cnt1, 32'd2);
    for (int k = 0; k < 800; k++)
      step(1, $urandom_range(0, 299) == 0, 2'($urandom), 2'($urandom), $urandom, $urandom,
           $urandom, $urandom, $urandom_range(0, 9) < 6);
    reset_dut(1);

    // Contention from reset with rsp_ready held high.
    reset_dut(0);
    for (int t = 0; t < 80 && ids.size() < 4; t++) begin
      step(0, 1'b0, 2'b11, 2'($urandom), $urandom, $urandom, $urandom, $urandom, 1'b1);
      if (obs_valid) ids.push_back(obs_id);
    end
    chk("contention_count", 32'(ids.size()), 32'd4);
    for (int k = 0; k < 4 && k < ids.size(); k++)
      chk("contention_order", 32'(ids[k]), 32'(k % 2));

    // Backpressure: response held across five stalled cycles.
    reset_dut(0);
    request(0, 1'b1, 32'h4120_0000, 32'h4000_0000, 1'b1, 1'b0, ok);
    for (int t = 0; t < 10 && !obs_valid; t++)
      step(0, 1'b0, 2'b11, 2'b00, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0);
    chk("bp_valid", 32'(obs_valid), 32'd1);
    snap_res = obs_res; snap_flags = obs_flags; snap_id = obs_id;
    for (int t = 0; t < 5; t++) begin
      step(0, 1'b0, 2'b11, 2'b00, $urandom, $urandom, $urandom, $urandom, 1'b0);
      chk("bp_result_stable", obs_res, snap_res);
      chk("bp_flags_stable", 32'(obs_flags), 32'(snap_flags));
      chk("bp_id_stable", 32'(obs_id), 32'(snap_id));
      chk("bp_ready_low", 32'(obs_ready), 32'd0);
    end
    step(0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("bp_release_valid", 32'(obs_valid), 32'd1);
    idle_step(0, 1'b1);
    chk("bp_after_valid", 32'(obs_valid), 32'd0);
    chk("bp_done_cnt1", obs_cnt1, 32'd1);

    // Reset during BUSY drops the transaction.
    reset_dut(0);
    request(0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, ok);
    idle_step(0, 1'b1);
    step(0, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int t = 0; t < 4; t++) begin
      idle_step(0, 1'b1);
      chk("rst_busy_no_rsp", 32'(obs_valid), 32'd0);
    end
    chk("rst_busy_cnt0", obs_cnt0, 32'd0);
    do_txn(0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4000_0000, 32'h4040_0000);
    idle_step(0, 1'b1);
    chk("rst_busy_after_cnt0", obs_cnt0, 32'd1);

    // Random traffic against the model.
    reset_dut(0);
    for (int k = 0; k < 2000; k++)
      step(0, $urandom_range(0, 299) == 0, 2'($urandom), 2'($urandom), $urandom, $urandom,
           $urandom, $urandom, $urandom_range(0, 9) < 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
